ni_packet_sender: RTL and testbench

Local-port packet transmitter for the Phoenix NoC router. Takes a packet request (destination XY address, payload length) from the attached IP core and drives the router's local input port: header flit (destination), size flit, then payload flits. Flow control uses the router's credit handshake. It produces the header flits that the router's XY routing logic decodes.

---
 rtl/ni_packet_sender.sv | 125 ++++++++++++
 tb/tb_ni_packet_sender.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packet_sender.sv
// rtl/ni_packet_sender.sv - Phoenix NoC local-port packet transmitter
//
// Sends one packet per accepted request into the router local input port:
// header flit (destination XY), size flit, then N payload flits passed
// straight through from the IP core, all under the router credit handshake.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               packet request, sampled only when idle
//   i_dest, i_size        destination XY address and payload count, latched on start
//   i_payload(_valid)     payload flit from the IP core
//   o_payload_ready       payload flit consumed this cycle if valid
//   o_tx, o_data_out      flit towards the router local port
//   i_credit              router local buffer accepts a flit this cycle
//   o_busy, o_done        packet in progress / one-cycle completion pulse
//   o_self                latched destination equals this node's address
//   o_pkt_count           completed packets, wrapping
module ni_packet_sender #(
    parameter int                  TAM_FLIT = 16,
    parameter logic [TAM_FLIT-1:0] adress   = '0
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [TAM_FLIT-1:0] i_dest,
    input  logic [TAM_FLIT-1:0] i_size,
    input  logic [TAM_FLIT-1:0] i_payload,
    input  logic                i_payload_valid,
    output logic                o_payload_ready,
    output logic                o_tx,
    output logic [TAM_FLIT-1:0] o_data_out,
    input  logic                i_credit,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_self,
    output logic [15:0]         o_pkt_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t              state;
    logic [TAM_FLIT-1:0] dest_q;
    logic [TAM_FLIT-1:0] size_q;
    logic [TAM_FLIT-1:0] remaining_q;
    logic [15:0]         pkt_count_q;
    logic                flit_xfer;

    // Flit-side outputs are combinational so payload flits pass through
    // without a bubble; none of them depends on i_start.
    always_comb begin
        o_tx            = 1'b0;
        o_data_out      = '0;
        o_payload_ready = 1'b0;
        case (state)
            S_HEADER: begin
                o_tx       = 1'b1;
                o_data_out = dest_q;
            end
            S_SIZE: begin
                o_tx       = 1'b1;
                o_data_out = size_q;
            end
            S_PAYLOAD: begin
                o_tx            = i_payload_valid;
                o_data_out      = i_payload;
                o_payload_ready = i_credit;
            end
            default: ;
        endcase
    end

    // In PAYLOAD this is also the payload consumption event.
    assign flit_xfer = o_tx && i_credit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            dest_q      <= '0;
            size_q      <= '0;
            remaining_q <= '0;
            pkt_count_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        dest_q      <= i_dest;
                        size_q      <= i_size;
                        remaining_q <= i_size;
                        state       <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (flit_xfer) state <= S_SIZE;
                end
                S_SIZE: begin
                    if (flit_xfer) state <= (size_q != '0) ? S_PAYLOAD : S_DONE;
                end
                S_PAYLOAD: begin
                    // remaining_q is at least 1 here, so the decrement cannot wrap.
                    if (flit_xfer) begin
                        remaining_q <= remaining_q - TAM_FLIT'(1);
                        if (remaining_q == TAM_FLIT'(1)) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    pkt_count_q <= pkt_count_q + 16'd1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_self      = o_busy && (dest_q == adress);
    assign o_pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ni_packet_sender.sv
// tb/tb_ni_packet_sender.sv - scoreboard bench for ni_packet_sender
module tb_ni_packet_sender;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_dest = '0;
    logic [15:0] i_size = '0;
    logic [15:0] i_payload = '0;
    logic        i_payload_valid = 1'b0;
    logic        o_payload_ready;
    logic        o_tx;
    logic [15:0] o_data_out;
    logic        i_credit = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_self;
    logic [15:0] o_pkt_count;

    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pay_q[$];
    logic [15:0] mon_exp;
    bit          pay_en = 1'b1;

    ni_packet_sender #(.TAM_FLIT(16), .adress(16'h0000)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_dest(i_dest),
        .i_size(i_size), .i_payload(i_payload), .i_payload_valid(i_payload_valid),
        .o_payload_ready(o_payload_ready), .o_tx(o_tx), .o_data_out(o_data_out),
        .i_credit(i_credit), .o_busy(o_busy), .o_done(o_done), .o_self(o_self),
        .o_pkt_count(o_pkt_count)
    );

    always #5 i_clk = ~i_clk;

    // Flit scoreboard: every transferred flit must match the next expected one.
    always @(negedge i_clk) begin
        if (!i_rst && o_tx && i_credit) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL flit_extra: got %h, expected no flit", o_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_data_out !== mon_exp) begin
                    failures++;
                    $display("FAIL flit_data: got %h, expected %h", o_data_out, mon_exp);
                end
            end
        end
        if (!i_rst && o_done) done_seen++;
    end

    // One clock; models the IP core payload source (pops on consumption).
    task automatic tick();
        bit cons;
        @(negedge i_clk);
        cons = i_payload_valid && o_payload_ready;
        @(posedge i_clk);
        #1;
        if (cons && pay_q.size() > 0) void'(pay_q.pop_front());
        i_payload_valid = pay_en && (pay_q.size() > 0);
        i_payload       = (pay_q.size() > 0) ? pay_q[0] : 16'h0000;
    endtask

    task automatic queue_pkt(input logic [15:0] dest, input logic [15:0] size,
                             input logic [15:0] base);
        exp_q.push_back(dest);
        exp_q.push_back(size);
        for (int k = 0; k < int'(size); k++) begin
            exp_q.push_back(base + 16'(k));
            pay_q.push_back(base + 16'(k));
        end
    endtask

    // Sends with credit held high; returns when DONE is reached or budget expires.
    task automatic send_pkt(input logic [15:0] dest, input logic [15:0] size,
                            input logic [15:0] base, output bit timeout, output int txc);
        queue_pkt(dest, size, base);
        i_dest = dest; i_size = size; i_start = 1'b1; i_credit = 1'b1;
        tick();
        i_start = 1'b0;
        timeout = 1'b1;
        txc = 0;
        for (int c = 0; c < 200; c++) begin
            if (o_done) begin
                timeout = 1'b0;
                break;
            end
            if (o_tx) txc++;
            tick();
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b1; i_dest = 16'h0304; i_size = 16'd2; i_credit = 1'b0;
        tick(); tick();
        checks++;
        if ({o_tx, o_busy, o_done, o_self, o_payload_ready, o_data_out, o_pkt_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got tx=%b busy=%b done=%b self=%b rdy=%b data=%h cnt=%h, expected all 0",
                     o_tx, o_busy, o_done, o_self, o_payload_ready, o_data_out, o_pkt_count);
        end
        i_rst = 1'b0;
        tick();
        checks++;
        if (o_tx !== 1'b1 || o_data_out !== 16'h0304) begin
            failures++;
            $display("FAIL header_after_reset: got tx=%b data=%h, expected tx=1 data=0304", o_tx, o_data_out);
        end
        i_start = 1'b0; i_dest = 16'h0000;
        tick(); tick();
        checks++;
        if (o_tx !== 1'b1 || o_data_out !== 16'h0304 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL header_hold_no_credit: got tx=%b data=%h busy=%b, expected 1 0304 1",
                     o_tx, o_data_out, o_busy);
        end
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_tx !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_header: got busy=%b tx=%b, expected 0 0", o_busy, o_tx);
        end
    endtask

    task automatic test_basic();
        bit to;
        int txc;
        int d0;
        d0 = done_seen;
        send_pkt(16'h0102, 16'd3, 16'h00A1, to, txc);
        checks++;
        if (to !== 1'b0 || txc != 5) begin
            failures++;
            $display("FAIL basic_flits: got timeout=%b tx_cycles=%0d, expected 0 5", to, txc);
        end
        checks++;
        if (o_tx !== 1'b0 || o_pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL basic_done_cycle: got tx=%b cnt=%0d, expected 0 0", o_tx, o_pkt_count);
        end
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pkt_count !== 16'd1 || done_seen - d0 != 1) begin
            failures++;
            $display("FAIL basic_complete: got done=%b busy=%b cnt=%0d pulses=%0d, expected 0 0 1 1",
                     o_done, o_busy, o_pkt_count, done_seen - d0);
        end
    endtask

    task automatic test_backpressure();
        bit finished;
        queue_pkt(16'h0102, 16'd3, 16'h00A1);
        i_dest = 16'h0102; i_size = 16'd3; i_start = 1'b1; i_credit = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            i_credit = 1'b0;
            tick();
            checks++;
            if (o_tx !== 1'b1 || o_data_out !== 16'h0003) begin
                failures++;
                $display("FAIL size_hold: got tx=%b data=%h, expected 1 0003", o_tx, o_data_out);
            end
        end
        i_credit = 1'b1;
        tick();
        finished = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (o_done) begin
                finished = 1'b1;
                break;
            end
            checks++;
            if (o_payload_ready !== i_credit) begin
                failures++;
                $display("FAIL ready_follows_credit: got %b, expected %b", o_payload_ready, i_credit);
            end
            i_credit = 1'($urandom_range(0, 1));
            pay_en   = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        pay_en = 1'b1;
        i_credit = 1'b1;
        checks++;
        if (!finished) begin
            failures++;
            $display("FAIL backpressure_timeout: got no done, expected done");
        end
        tick();
        checks++;
        if (o_pkt_count !== 16'd2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL backpressure_complete: got cnt=%0d pending=%0d, expected 2 0",
                     o_pkt_count, exp_q.size());
        end
    endtask

    task automatic test_zero_size();
        bit to;
        int txc;
        send_pkt(16'h0201, 16'd0, 16'h0000, to, txc);
        checks++;
        if (to !== 1'b0 || txc != 2) begin
            failures++;
            $display("FAIL zero_flits: got timeout=%b tx_cycles=%0d, expected 0 2", to, txc);
        end
        tick();
        checks++;
        if (o_pkt_count !== 16'd3) begin
            failures++;
            $display("FAIL zero_count: got %0d, expected 3", o_pkt_count);
        end
    endtask

    task automatic test_self_ignore_start();
        int d0;
        d0 = done_seen;
        queue_pkt(16'h0000, 16'd1, 16'h55AA);
        i_dest = 16'h0000; i_size = 16'd1; i_start = 1'b1; i_credit = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick();
        checks++;
        if (o_self !== 1'b1 || o_busy !== 1'b1 || o_data_out !== 16'h55AA) begin
            failures++;
            $display("FAIL self_payload: got self=%b busy=%b data=%h, expected 1 1 55aa",
                     o_self, o_busy, o_data_out);
        end
        i_credit = 1'b0; i_start = 1'b1; i_dest = 16'h0999; i_size = 16'd7;
        tick();
        i_start = 1'b0; i_credit = 1'b1;
        tick();
        checks++;
        if (o_done !== 1'b1 || o_self !== 1'b1) begin
            failures++;
            $display("FAIL self_done: got done=%b self=%b, expected 1 1", o_done, o_self);
        end
        tick();
        checks++;
        if (o_self !== 1'b0 || o_pkt_count !== 16'd4) begin
            failures++;
            $display("FAIL self_idle: got self=%b cnt=%0d, expected 0 4", o_self, o_pkt_count);
        end
        tick(); tick();
        checks++;
        if (o_busy !== 1'b0 || done_seen - d0 != 1) begin
            failures++;
            $display("FAIL start_ignored: got busy=%b pulses=%0d, expected 0 1", o_busy, done_seen - d0);
        end
    endtask

    task automatic test_abort_wrap();
        bit to;
        int txc;
        int d0;
        d0 = done_seen;
        queue_pkt(16'h0102, 16'd5, 16'h0B00);
        i_dest = 16'h0102; i_size = 16'd5; i_start = 1'b1; i_credit = 1'b1;
        tick();
        i_start = 1'b0;
        tick(); tick(); tick(); tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++;
        if (o_tx !== 1'b0 || o_busy !== 1'b0 || o_pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL abort: got tx=%b busy=%b cnt=%0d, expected 0 0 0", o_tx, o_busy, o_pkt_count);
        end
        exp_q.delete();
        pay_q.delete();
        tick(); tick(); tick();
        checks++;
        if (done_seen != d0 || o_tx !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got pulses=%0d tx=%b, expected 0 0", done_seen - d0, o_tx);
        end
        force dut.pkt_count_q = 16'hFFFF;
        tick();
        release dut.pkt_count_q;
        send_pkt(16'h0201, 16'd0, 16'h0000, to, txc);
        checks++;
        if (to !== 1'b0 || o_pkt_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL wrap_preload: got timeout=%b cnt=%h, expected 0 ffff", to, o_pkt_count);
        end
        tick();
        checks++;
        if (o_pkt_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap: got %h, expected 0000", o_pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_size();
        test_self_ignore_start();
        test_abort_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL flits_missing: got %0d pending, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
